// File: rtl/common_pkg.sv
// Shared types and register-map constants for the NLP16 bus responder.
// Optional timer is enabled with the NLP16_MMIO_TIMER_EN macro.
package common_pkg;

  typedef logic [15:0] word_t;

  // Register offsets from MMIO_BASE
  localparam word_t OFF_GPIO = 16'd0;
  localparam word_t OFF_TCNT = 16'd1;
  localparam word_t OFF_TCMP = 16'd2;
  localparam word_t OFF_TCTL = 16'd3;

  // TCTL bit positions
  localparam int unsigned TCTL_EN_BIT   = 0;
  localparam int unsigned TCTL_AR_BIT   = 1;
  localparam int unsigned TCTL_FLAG_BIT = 15;

endpackage

// File: rtl/nlp16_bus_responder_if.sv
// Core-side word bus: qualified strobes, address, write data and read data.
// The responder is the slave; the core (or the top feeding the timer) is the master.
interface nlp16_bus_responder_if;
  import common_pkg::*;

  logic  wr;
  logic  rd;
  word_t address;
  word_t wdata;
  word_t rdata;

  modport master (output wr, rd, address, wdata, input rdata);
  modport slave  (input wr, rd, address, wdata, output rdata);

endinterface

// File: rtl/nlp16_timer.sv
// Free-running compare timer (TCNT/TCMP/TCTL) with match flag as level IRQ.
// Only instantiated when NLP16_MMIO_TIMER_EN is defined.
module nlp16_timer
  import common_pkg::*;
#(
  parameter word_t MMIO_BASE = 16'hFF00
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  nlp16_bus_responder_if.slave    bus,
  output logic                    o_irq
);

  word_t tcnt_q, tcnt_d;
  word_t tcmp_q, tcmp_d;
  logic  en_q, en_d;
  logic  ar_q, ar_d;
  logic  flag_q, flag_d;

  logic sel_tcnt, sel_tcmp, sel_tctl, match;

  assign sel_tcnt = (bus.address == MMIO_BASE + OFF_TCNT);
  assign sel_tcmp = (bus.address == MMIO_BASE + OFF_TCMP);
  assign sel_tctl = (bus.address == MMIO_BASE + OFF_TCTL);
  assign match    = en_q && (tcnt_q == tcmp_q);

  // Next-state: count/reload, then core writes override; a match beats a W1C clear
  always_comb begin
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    en_d   = en_q;
    ar_d   = ar_q;
    flag_d = flag_q;
    if (en_q) begin
      tcnt_d = (match && ar_q) ? '0 : tcnt_q + 16'd1;
    end
    if (bus.wr && sel_tcnt) tcnt_d = bus.wdata;
    if (bus.wr && sel_tcmp) tcmp_d = bus.wdata;
    if (bus.wr && sel_tctl) begin
      en_d = bus.wdata[TCTL_EN_BIT];
      ar_d = bus.wdata[TCTL_AR_BIT];
      if (bus.wdata[TCTL_FLAG_BIT]) flag_d = 1'b0;
    end
    if (match) flag_d = 1'b1;
  end

  // Timer register bank, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt_q <= '0;
      tcmp_q <= '0;
      en_q   <= 1'b0;
      ar_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      en_q   <= en_d;
      ar_q   <= ar_d;
      flag_q <= flag_d;
    end
  end

  // Read mux of current register values; unused TCTL bits read as zero
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (sel_tcnt) bus.rdata = tcnt_q;
      if (sel_tcmp) bus.rdata = tcmp_q;
      if (sel_tctl) begin
        bus.rdata[TCTL_FLAG_BIT] = flag_q;
        bus.rdata[TCTL_AR_BIT]   = ar_q;
        bus.rdata[TCTL_EN_BIT]   = en_q;
      end
    end
  end

  assign o_irq = flag_q;

endmodule

// File: rtl/nlp16_bus_responder.sv
// NLP16 bus responder: RAM at 0x0000, GPIO and optional timer at MMIO_BASE.
// Define NLP16_MMIO_TIMER_EN to build the timer (MMIO_BASE+1..+3, o_irq);
// otherwise those addresses are unmapped and o_irq is tied low.
module nlp16_bus_responder
  import common_pkg::*;
#(
  parameter int    RAM_AW    = 12,
  parameter word_t MMIO_BASE = 16'hFF00
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_wr,
  input  logic  i_rd,
  input  word_t i_address,
  input  word_t i_bus,
  output word_t o_bus,
  output word_t o_gpio,
  output logic  o_irq,
  output logic  o_bus_err
);

  word_t mem [0:(1<<RAM_AW)-1];

  word_t o_bus_q, o_bus_d;
  word_t gpio_q, gpio_d;
  logic  bus_err_q, bus_err_d;

  logic  wr_ok, rd_ok, conflict;
  logic  ram_sel, gpio_sel, tmr_sel, mapped;
  word_t tmr_rdata;

  // Simultaneous strobes are a protocol error and perform no access
  assign wr_ok    = i_wr & ~i_rd;
  assign rd_ok    = i_rd & ~i_wr;
  assign conflict = i_rd & i_wr;

  assign ram_sel  = ((i_address >> RAM_AW) == '0);
  assign gpio_sel = (i_address == MMIO_BASE + OFF_GPIO);
  assign mapped   = ram_sel | gpio_sel | tmr_sel;

`ifdef NLP16_MMIO_TIMER_EN
  nlp16_bus_responder_if tmr_bus ();

  assign tmr_sel         = (i_address == MMIO_BASE + OFF_TCNT) ||
                           (i_address == MMIO_BASE + OFF_TCMP) ||
                           (i_address == MMIO_BASE + OFF_TCTL);
  assign tmr_bus.wr      = wr_ok;
  assign tmr_bus.rd      = rd_ok;
  assign tmr_bus.address = i_address;
  assign tmr_bus.wdata   = i_bus;
  assign tmr_rdata       = tmr_bus.rdata;

  nlp16_timer #(.MMIO_BASE(MMIO_BASE)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (tmr_bus.slave),
    .o_irq   (o_irq)
  );
`else
  assign tmr_sel   = 1'b0;
  assign tmr_rdata = '0;
  assign o_irq     = 1'b0;
`endif

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge i_clk) begin
    if (wr_ok && ram_sel) mem[i_address[RAM_AW-1:0]] <= i_bus;
  end

  // Read data capture, GPIO write and error pulse decode
  always_comb begin
    o_bus_d   = o_bus_q;
    gpio_d    = gpio_q;
    bus_err_d = conflict | ((wr_ok | rd_ok) & ~mapped);
    if (rd_ok) begin
      if (ram_sel)       o_bus_d = mem[i_address[RAM_AW-1:0]];
      else if (gpio_sel) o_bus_d = gpio_q;
      else if (tmr_sel)  o_bus_d = tmr_rdata;
      else               o_bus_d = '0;
    end
    if (wr_ok && gpio_sel) gpio_d = i_bus;
  end

  // Output registers; reset also discards any read in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bus_q   <= '0;
      gpio_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      o_bus_q   <= o_bus_d;
      gpio_q    <= gpio_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign o_bus     = o_bus_q;
  assign o_gpio    = gpio_q;
  assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_nlp16_bus_responder.sv
// Scoreboard bench for nlp16_bus_responder: each issued cycle pushes the
// expected post-edge outputs from a behavioural model; a monitor pops and compares.
// Works for both builds (NLP16_MMIO_TIMER_EN defined or not).
module tb_nlp16_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] gpio;
  logic        irq;
  logic        bus_err;

  nlp16_bus_responder_if bus_if ();

  nlp16_bus_responder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr      (bus_if.wr),
    .i_rd      (bus_if.rd),
    .i_address (bus_if.address),
    .i_bus     (bus_if.wdata),
    .o_bus     (bus_if.rdata),
    .o_gpio    (gpio),
    .o_irq     (irq),
    .o_bus_err (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bus;
    logic        err;
    logic [15:0] gpio;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Behavioural model state
  logic [15:0] m_mem [0:4095];
  logic [15:0] m_bus, m_gpio, m_cnt, m_cmp;
  bit          m_en, m_ar, m_flag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [15:0] a);
    if (a < 16'd4096) return 1'b1;
    if (a == 16'hFF00) return 1'b1;
`ifdef NLP16_MMIO_TIMER_EN
    if (a >= 16'hFF01 && a <= 16'hFF03) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [15:0] peek(input logic [15:0] a);
    if (a < 16'd4096) return m_mem[a[11:0]];
    if (a == 16'hFF00) return m_gpio;
`ifdef NLP16_MMIO_TIMER_EN
    if (a == 16'hFF01) return m_cnt;
    if (a == 16'hFF02) return m_cmp;
    if (a == 16'hFF03) return {m_flag, 13'd0, m_ar, m_en};
`endif
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_bus = 16'h0; m_gpio = 16'h0; m_cnt = 16'h0; m_cmp = 16'h0;
    m_en = 1'b0; m_ar = 1'b0; m_flag = 1'b0;
  endtask

  // Issue one bus cycle and record what the outputs must look like after the edge
  task automatic do_cycle(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
    bit          only_wr, only_rd, err, hit;
    logic [15:0] next_cnt;
    bit          next_flag;
    exp_t        e;
    @(negedge clk);
    bus_if.wr = wr; bus_if.rd = rd; bus_if.address = a; bus_if.wdata = d;
    only_wr = wr && !rd;
    only_rd = rd && !wr;
    err = (wr && rd) || ((wr || rd) && !is_mapped(a));
    if (only_rd) m_bus = peek(a);
    // Timer advances from its pre-edge state; core writes to TCNT take priority
    hit = m_en && (m_cnt == m_cmp);
    next_cnt = m_cnt;
    if (m_en) next_cnt = (hit && m_ar) ? 16'h0 : 16'(m_cnt + 16'd1);
    next_flag = m_flag;
    if (only_wr && is_mapped(a)) begin
      if (a < 16'd4096) m_mem[a[11:0]] = d;
      else if (a == 16'hFF00) m_gpio = d;
      else if (a == 16'hFF01) next_cnt = d;
      else if (a == 16'hFF02) m_cmp = d;
      else if (a == 16'hFF03) begin
        m_en = d[0]; m_ar = d[1];
        if (d[15]) next_flag = 1'b0;
      end
    end
    if (hit) next_flag = 1'b1;
`ifdef NLP16_MMIO_TIMER_EN
    m_cnt = next_cnt; m_flag = next_flag;
`endif
    e.bus = m_bus; e.err = err; e.gpio = m_gpio; e.irq = m_flag;
    q.push_back(e);
  endtask

  // Monitor: compare every post-edge output set against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cycle_outputs", {bus_if.rdata, bus_err, gpio, irq}, {e.bus, e.err, e.gpio, e.irq});
      end
    end
  end

  initial begin
    logic [15:0] a;
    int          r;
    bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.address = 16'h0; bus_if.wdata = 16'h0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_obus", bus_if.rdata, 16'h0);
    chk("reset_gpio", gpio, 16'h0);
    chk("reset_err", bus_err, 1'b0);
    chk("reset_irq", irq, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Preload the RAM window used by random reads
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 16'h0010 + 16'(i), 16'($urandom));

    // RAM write then read on the next cycle, held while idle
    do_cycle(1'b1, 1'b0, 16'h0010, 16'h1305);
    do_cycle(1'b0, 1'b1, 16'h0010, 16'h0);
    repeat (3) do_cycle(1'b0, 1'b0, 16'h0, 16'h0);

    // GPIO write and read-back
    do_cycle(1'b1, 1'b0, 16'hFF00, 16'h0A05);
    do_cycle(1'b0, 1'b1, 16'hFF00, 16'h0);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0);

    // Unmapped read and strobe conflict
    do_cycle(1'b0, 1'b1, 16'h8000, 16'h0);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle(1'b0, 1'b1, 16'h0010, 16'h0);
    do_cycle(1'b0, 1'b1, 16'hFF01, 16'h0);
    do_cycle(1'b1, 1'b0, 16'h1000, 16'h5555);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0);

`ifdef NLP16_MMIO_TIMER_EN
    // Timer: compare 5, enable with autoreload, watch count wrap to 0
    do_cycle(1'b1, 1'b0, 16'hFF01, 16'h0);
    do_cycle(1'b1, 1'b0, 16'hFF02, 16'h0005);
    do_cycle(1'b1, 1'b0, 16'hFF03, 16'h0003);
    repeat (9) do_cycle(1'b0, 1'b1, 16'hFF01, 16'h0);
    do_cycle(1'b0, 1'b1, 16'hFF03, 16'h0);
    if (m_cnt == m_cmp) do_cycle(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle(1'b1, 1'b0, 16'hFF03, 16'h8003);
    for (int k = 0; k < 20 && m_cnt != m_cmp; k++) do_cycle(1'b0, 1'b1, 16'hFF03, 16'h0);
    do_cycle(1'b1, 1'b0, 16'hFF03, 16'h8003);
    do_cycle(1'b0, 1'b1, 16'hFF03, 16'h0);
    do_cycle(1'b1, 1'b0, 16'hFF01, 16'hFFFE);
    do_cycle(1'b1, 1'b0, 16'hFF03, 16'h8001);
    repeat (4) do_cycle(1'b0, 1'b1, 16'hFF01, 16'h0);
`endif

    // Randomized traffic over RAM window, registers and unmapped holes
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: a = 16'h0010 + 16'($urandom_range(0, 15));
        5:             a = 16'hFF00;
        6:             a = 16'hFF01 + 16'($urandom_range(0, 2));
        7:             a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h1000;
        default:       a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'hFF04;
      endcase
      r = $urandom_range(0, 9);
      do_cycle(r >= 4 && r <= 7, r <= 3 || r == 7, a, 16'($urandom));
    end

    // Reset mid-cycle after a read; RAM must survive
    do_cycle(1'b1, 1'b0, 16'h0010, 16'h1305);
    do_cycle(1'b1, 1'b0, 16'hFF00, 16'hA5A5);
    do_cycle(1'b0, 1'b1, 16'h0010, 16'h0);
    @(posedge clk);
    #2;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_obus", bus_if.rdata, 16'h0);
    chk("async_rst_gpio", gpio, 16'h0);
    chk("async_rst_err", bus_err, 1'b0);
    chk("async_rst_irq", irq, 1'b0);
    @(negedge clk);
    bus_if.wr = 1'b0; bus_if.rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle(1'b0, 1'b1, 16'h0010, 16'h0);
    do_cycle(1'b0, 1'b1, 16'hFF01, 16'h0);
    repeat (2) do_cycle(1'b0, 1'b0, 16'h0, 16'h0);

    // Drain the scoreboard
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nlp16_bus_responder.md
NLP16_BUS_RESPONDER -- requirements
Module: nlp16_bus_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RAM_AW, 12, RAM word-address width (2^RAM_AW 16-bit words at 0x0000).
- MMIO_BASE, 16'hFF00, base address of the register block.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- i_clk  input  1  single clock, all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_wr  input  1  core write strobe.
- i_rd  input  1  core read strobe.
- i_address  input  16  core word address.
- i_bus  input  16  write data from core.
- o_bus  output  16  read data to core.
- o_gpio  output  16  GPIO output register.
- o_irq  output  1  timer match flag, level.
- o_bus_err  output  1  one-cycle error pulse.

Function
REQ-003 The address map SHALL be:
- RAM: 0x0000..2^RAM_AW-1.
- GPIO: MMIO_BASE+0, R/W.
- TCNT: MMIO_BASE+1, R/W.
- TCMP: MMIO_BASE+2, R/W.
- TCTL: MMIO_BASE+3; bit0 enable, bit1 autoreload, bit15 match flag (read; write 1 to clear).
- All other addresses unmapped.

REQ-004 Writes SHALL commit at the rising edge where i_wr=1 and i_rd=0.

REQ-005 A read sampled at edge N (i_rd=1, i_wr=0) SHALL present data on o_bus from edge N through the next read-sample edge, giving one cycle of latency; o_bus SHALL hold its last value when no read occurs.

REQ-006 i_rd=1 and i_wr=1 in the same cycle SHALL perform no access, leave o_bus unchanged, and pulse o_bus_err for one cycle.

REQ-007 Any access to an unmapped address SHALL ignore writes, return 16'h0000 for reads, and pulse o_bus_err for one cycle.

REQ-008 A RAM write at edge N followed by a read of the same address at edge N+1 SHALL return the new data.

REQ-009 TCNT SHALL increment by 1 per clock while TCTL.enable=1, wrapping 0xFFFF->0x0000.

REQ-010 When TCNT==TCMP with enable=1, the flag SHALL set on that edge; with autoreload=1 TCNT SHALL load 0, otherwise TCNT SHALL increment normally.

REQ-011 A core write to TCNT in the same cycle as an increment or reload SHALL win.

REQ-012 A flag set and a W1C clear in the same cycle SHALL leave the flag set.

REQ-013 o_irq SHALL equal TCTL bit15.

REQ-014 Reads of TCTL SHALL return bits 14:2 as 0.

Reset
REQ-015 While i_rst_n=0, the block SHALL clear o_bus, o_gpio, TCNT, TCMP, TCTL, o_irq and o_bus_err to 0 immediately, independent of i_clk.

REQ-016 RAM contents SHALL NOT be reset.

REQ-017 A read in flight when reset asserts SHALL be discarded; o_bus SHALL remain 0 until the next read.

Configuration
REQ-018 With macro NLP16_MMIO_TIMER_EN defined, the timer (TCNT, TCMP, TCTL, o_irq) SHALL be built as specified above.

REQ-019 Without NLP16_MMIO_TIMER_EN, MMIO_BASE+1..+3 SHALL be unmapped per REQ-007, o_irq SHALL be tied to 0, and no timer logic SHALL be instantiated.

Structure
REQ-020 common_pkg SHALL hold:
- the 16-bit bus word typedef;
- register offset constants (GPIO, TCNT, TCMP, TCTL);
- TCTL bit-position constants.

REQ-021 Timer logic SHALL be the sub-module nlp16_timer, instantiated only under NLP16_MMIO_TIMER_EN.

REQ-022 RAM SHALL be a single-port synchronous array inside nlp16_bus_responder.

Verification
REQ-023 Write 0x0010<=16'h1305, then read 0x0010 on the next cycle -> o_bus=16'h1305 one cycle after the read strobe, held while idle.

REQ-024 Write GPIO (0xFF00)<=16'h0A05 -> o_gpio=16'h0A05 after that edge; read back -> 16'h0A05; o_bus_err stays 0.

REQ-025 TCMP<=5, TCTL<=16'h0003 -> TCNT runs 0..5, flag and o_irq set at match, TCNT reloads to 0; write TCTL<=16'h8003 -> flag clears; a clear coincident with a match keeps the flag set.

REQ-026 Read 0x8000 with RAM_AW=12 -> o_bus=16'h0000 and a one-cycle o_bus_err; i_rd=i_wr=1 at 0x0010 -> RAM unchanged, o_bus unchanged, o_bus_err pulses.

REQ-027 Read 0x0010 (holding 16'h1305), then assert i_rst_n=0 mid-cycle -> o_bus, o_gpio and timer registers go to 0 at once; after release, a read of 0x0010 returns 16'h1305.

REQ-028 Build without NLP16_MMIO_TIMER_EN; read 0xFF01 -> 16'h0000, o_bus_err pulses, o_irq constant 0.
